// File: rtl/idct_block_loader.sv
// Coefficient loader in front of the IDCT: collects 64 coefficients (raster or zigzag order)
// into a shadow buffer, publishes each complete block on x0..x63 and delays its valid tag.
module idct_block_loader #(
    parameter int WIDTH        = 16,
    parameter bit ZIGZAG       = 1'b1,
    parameter int IDCT_LATENCY = 29
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,
    output logic signed [WIDTH-1:0] x8,  x9,  x10, x11, x12, x13, x14, x15,
    output logic signed [WIDTH-1:0] x16, x17, x18, x19, x20, x21, x22, x23,
    output logic signed [WIDTH-1:0] x24, x25, x26, x27, x28, x29, x30, x31,
    output logic signed [WIDTH-1:0] x32, x33, x34, x35, x36, x37, x38, x39,
    output logic signed [WIDTH-1:0] x40, x41, x42, x43, x44, x45, x46, x47,
    output logic signed [WIDTH-1:0] x48, x49, x50, x51, x52, x53, x54, x55,
    output logic signed [WIDTH-1:0] x56, x57, x58, x59, x60, x61, x62, x63,
    output logic                    blk_valid,
    output logic                    idct_out_valid,
    output logic                    err_len
);

    typedef logic signed [WIDTH-1:0] coef_t;

    // Stream position -> raster index for JPEG zigzag order.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    coef_t                   shadow_q [64];
    coef_t                   x_q [64];
    coef_t                   x_d [64];
    logic [5:0]              cnt_q, cnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    blk_valid_q, blk_valid_d;
    logic                    err_len_q, err_len_d;
    logic [IDCT_LATENCY-1:0] tag_q, tag_d;
    logic                    accept;
    logic [5:0]              dst;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        accept      = in_valid && in_ready_q;
        dst         = ZIGZAG ? ZZ[cnt_q] : cnt_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        blk_valid_d = 1'b0;
        err_len_d   = 1'b0;
        in_ready_d  = 1'b1;
        tag_d       = {tag_q[IDCT_LATENCY-2:0], blk_valid_q};
        if (accept) begin
            if (cnt_q == 6'd63) begin
                // Final word bypasses the shadow so the block is published at this same edge.
                for (int i = 0; i < 64; i++) begin
                    x_d[i] = (6'(i) == dst) ? in_data : shadow_q[i];
                end
                blk_valid_d = 1'b1;
                err_len_d   = !in_last;
                cnt_d       = 6'd0;
            end else if (in_last) begin
                err_len_d = 1'b1;
                cnt_d     = 6'd0;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 6'd0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
            tag_q       <= '0;
            for (int i = 0; i < 64; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            blk_valid_q <= blk_valid_d;
            err_len_q   <= err_len_d;
            tag_q       <= tag_d;
            x_q         <= x_d;
        end
    end

    // NOTE: the shadow buffer has no reset; every entry is rewritten before it can reach x_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            shadow_q[dst] <= in_data;
        end
    end

    assign in_ready       = in_ready_q;
    assign blk_valid      = blk_valid_q;
    assign err_len        = err_len_q;
    assign idct_out_valid = tag_q[IDCT_LATENCY-1];

    assign x0  = x_q[0];  assign x1  = x_q[1];  assign x2  = x_q[2];  assign x3  = x_q[3];
    assign x4  = x_q[4];  assign x5  = x_q[5];  assign x6  = x_q[6];  assign x7  = x_q[7];
    assign x8  = x_q[8];  assign x9  = x_q[9];  assign x10 = x_q[10]; assign x11 = x_q[11];
    assign x12 = x_q[12]; assign x13 = x_q[13]; assign x14 = x_q[14]; assign x15 = x_q[15];
    assign x16 = x_q[16]; assign x17 = x_q[17]; assign x18 = x_q[18]; assign x19 = x_q[19];
    assign x20 = x_q[20]; assign x21 = x_q[21]; assign x22 = x_q[22]; assign x23 = x_q[23];
    assign x24 = x_q[24]; assign x25 = x_q[25]; assign x26 = x_q[26]; assign x27 = x_q[27];
    assign x28 = x_q[28]; assign x29 = x_q[29]; assign x30 = x_q[30]; assign x31 = x_q[31];
    assign x32 = x_q[32]; assign x33 = x_q[33]; assign x34 = x_q[34]; assign x35 = x_q[35];
    assign x36 = x_q[36]; assign x37 = x_q[37]; assign x38 = x_q[38]; assign x39 = x_q[39];
    assign x40 = x_q[40]; assign x41 = x_q[41]; assign x42 = x_q[42]; assign x43 = x_q[43];
    assign x44 = x_q[44]; assign x45 = x_q[45]; assign x46 = x_q[46]; assign x47 = x_q[47];
    assign x48 = x_q[48]; assign x49 = x_q[49]; assign x50 = x_q[50]; assign x51 = x_q[51];
    assign x52 = x_q[52]; assign x53 = x_q[53]; assign x54 = x_q[54]; assign x55 = x_q[55];
    assign x56 = x_q[56]; assign x57 = x_q[57]; assign x58 = x_q[58]; assign x59 = x_q[59];
    assign x60 = x_q[60]; assign x61 = x_q[61]; assign x62 = x_q[62]; assign x63 = x_q[63];

endmodule

// File: tb/tb_idct_block_loader.sv
// Bench for idct_block_loader: raster and zigzag instances share one stream and are checked
// every cycle against a block-level model, plus literal spot checks per scenario.
module tb_idct_block_loader;

    localparam int LAT = 29;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [15:0]  in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_last = 1'b0;

    wire                 rdy_r, blk_r, ov_r, err_r;
    wire                 rdy_z, blk_z, ov_z, err_z;
    wire signed [15:0]   xr [64];
    wire signed [15:0]   xz [64];

    int n_cmp = 0;
    int n_bad = 0;

    int zz_pos [64];

    int mcyc = 0;
    int blk_t [$];
    int ov_t [$];
    int n_err = 0;

    always #5 clk = ~clk;

    idct_block_loader #(.WIDTH(16), .ZIGZAG(1'b0), .IDCT_LATENCY(LAT)) dut_r (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_r), .blk_valid(blk_r), .idct_out_valid(ov_r), .err_len(err_r),
        .x0(xr[0]),   .x1(xr[1]),   .x2(xr[2]),   .x3(xr[3]),   .x4(xr[4]),   .x5(xr[5]),   .x6(xr[6]),   .x7(xr[7]),
        .x8(xr[8]),   .x9(xr[9]),   .x10(xr[10]), .x11(xr[11]), .x12(xr[12]), .x13(xr[13]), .x14(xr[14]), .x15(xr[15]),
        .x16(xr[16]), .x17(xr[17]), .x18(xr[18]), .x19(xr[19]), .x20(xr[20]), .x21(xr[21]), .x22(xr[22]), .x23(xr[23]),
        .x24(xr[24]), .x25(xr[25]), .x26(xr[26]), .x27(xr[27]), .x28(xr[28]), .x29(xr[29]), .x30(xr[30]), .x31(xr[31]),
        .x32(xr[32]), .x33(xr[33]), .x34(xr[34]), .x35(xr[35]), .x36(xr[36]), .x37(xr[37]), .x38(xr[38]), .x39(xr[39]),
        .x40(xr[40]), .x41(xr[41]), .x42(xr[42]), .x43(xr[43]), .x44(xr[44]), .x45(xr[45]), .x46(xr[46]), .x47(xr[47]),
        .x48(xr[48]), .x49(xr[49]), .x50(xr[50]), .x51(xr[51]), .x52(xr[52]), .x53(xr[53]), .x54(xr[54]), .x55(xr[55]),
        .x56(xr[56]), .x57(xr[57]), .x58(xr[58]), .x59(xr[59]), .x60(xr[60]), .x61(xr[61]), .x62(xr[62]), .x63(xr[63])
    );

    idct_block_loader #(.WIDTH(16), .ZIGZAG(1'b1), .IDCT_LATENCY(LAT)) dut_z (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_z), .blk_valid(blk_z), .idct_out_valid(ov_z), .err_len(err_z),
        .x0(xz[0]),   .x1(xz[1]),   .x2(xz[2]),   .x3(xz[3]),   .x4(xz[4]),   .x5(xz[5]),   .x6(xz[6]),   .x7(xz[7]),
        .x8(xz[8]),   .x9(xz[9]),   .x10(xz[10]), .x11(xz[11]), .x12(xz[12]), .x13(xz[13]), .x14(xz[14]), .x15(xz[15]),
        .x16(xz[16]), .x17(xz[17]), .x18(xz[18]), .x19(xz[19]), .x20(xz[20]), .x21(xz[21]), .x22(xz[22]), .x23(xz[23]),
        .x24(xz[24]), .x25(xz[25]), .x26(xz[26]), .x27(xz[27]), .x28(xz[28]), .x29(xz[29]), .x30(xz[30]), .x31(xz[31]),
        .x32(xz[32]), .x33(xz[33]), .x34(xz[34]), .x35(xz[35]), .x36(xz[36]), .x37(xz[37]), .x38(xz[38]), .x39(xz[39]),
        .x40(xz[40]), .x41(xz[41]), .x42(xz[42]), .x43(xz[43]), .x44(xz[44]), .x45(xz[45]), .x46(xz[46]), .x47(xz[47]),
        .x48(xz[48]), .x49(xz[49]), .x50(xz[50]), .x51(xz[51]), .x52(xz[52]), .x53(xz[53]), .x54(xz[54]), .x55(xz[55]),
        .x56(xz[56]), .x57(xz[57]), .x58(xz[58]), .x59(xz[59]), .x60(xz[60]), .x61(xz[61]), .x62(xz[62]), .x63(xz[63])
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic signed [15:0] act [64],
                             input logic signed [15:0] exp [64]);
        int idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (act[i] !== exp[i]) idx = i;
        end
        check($sformatf("%s[%0d]", name, idx), int'(act[idx]), int'(exp[idx]));
    endtask

    // Reference model: tracks stream position, builds each block in raster order and
    // schedules the delayed tag; compared against both instances every cycle.
    initial begin : model_cmp
        int k, pos, edge_n;
        bit m_ready, m_blk, m_err, m_ov, s_rst, s_valid, s_last;
        logic signed [15:0] s_data;
        int due [$];
        logic signed [15:0] part_r [64];
        logic signed [15:0] part_z [64];
        logic signed [15:0] m_xr [64];
        logic signed [15:0] m_xz [64];
        logic signed [15:0] a_r [64];
        logic signed [15:0] a_z [64];

        // Zigzag walks the anti-diagonals, alternating direction.
        k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s < 7 ? 0 : s - 7); r--) begin
                    zz_pos[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = (s < 7 ? 0 : s - 7); r <= (s < 8 ? s : 7); r++) begin
                    zz_pos[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
        pos = 0; edge_n = 0;
        m_ready = 0; m_blk = 0; m_err = 0; m_ov = 0;
        for (int i = 0; i < 64; i++) begin
            part_r[i] = '0; part_z[i] = '0; m_xr[i] = '0; m_xz[i] = '0;
        end
        forever begin
            @(posedge clk);
            s_rst = rst; s_valid = in_valid; s_last = in_last; s_data = in_data;
            edge_n++;
            m_blk = 0; m_err = 0; m_ov = 0;
            if (s_rst) begin
                pos = 0;
                m_ready = 0;
                due.delete();
                for (int i = 0; i < 64; i++) begin
                    m_xr[i] = '0; m_xz[i] = '0;
                end
            end else begin
                for (int i = due.size() - 1; i >= 0; i--) begin
                    if (due[i] == edge_n) begin
                        m_ov = 1;
                        due.delete(i);
                    end
                end
                if (s_valid && m_ready) begin
                    part_r[pos] = s_data;
                    part_z[zz_pos[pos]] = s_data;
                    if (pos == 63) begin
                        m_xr = part_r;
                        m_xz = part_z;
                        m_blk = 1;
                        m_err = !s_last;
                        pos = 0;
                        due.push_back(edge_n + LAT);
                    end else if (s_last) begin
                        m_err = 1;
                        pos = 0;
                    end else begin
                        pos++;
                    end
                end
                m_ready = 1;
            end
            @(negedge clk);
            for (int i = 0; i < 64; i++) begin
                a_r[i] = xr[i]; a_z[i] = xz[i];
            end
            check("ready_r", int'(rdy_r), int'(m_ready));
            check("ready_z", int'(rdy_z), int'(m_ready));
            check("blk_r", int'(blk_r), int'(m_blk));
            check("blk_z", int'(blk_z), int'(m_blk));
            check("err_r", int'(err_r), int'(m_err));
            check("err_z", int'(err_z), int'(m_err));
            check("ov_r", int'(ov_r), int'(m_ov));
            check("ov_z", int'(ov_z), int'(m_ov));
            check_vec("x_r", a_r, m_xr);
            check_vec("x_z", a_z, m_xz);
        end
    end

    // Event log of DUT pulses for timing-distance checks.
    always @(negedge clk) begin
        mcyc++;
        if (blk_r) blk_t.push_back(mcyc);
        if (ov_r) ov_t.push_back(mcyc);
        if (err_r) n_err++;
    end

    task automatic drive(input bit v, input logic signed [15:0] d, input bit l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'sd0, 1'b0);
    endtask

    task automatic send_words(input int base, input int step, input int n, input bit last_at_end);
        for (int w = 0; w < n; w++) begin
            drive(1'b1, 16'(base + step * w), last_at_end && (w == n - 1));
        end
    endtask

    initial begin : stim
        int k, w, c, nz;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // 1: raster ramp 0,-1,...,-63
        send_words(0, -1, 64, 1'b1);
        check("s1_blk", int'(blk_r), 1);
        check("s1_x5", int'(xr[5]), -5);
        check("s1_x63", int'(xr[63]), -63);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!ov_r && k < 40);
        check("s1_ov_latency", k, LAT);

        // 2: value k at stream position k
        send_words(0, 1, 64, 1'b1);
        check("s2_z_x0", int'(xz[0]), 0);
        check("s2_z_x8", int'(xz[8]), 2);
        check("s2_z_x16", int'(xz[16]), 3);
        check("s2_z_x2", int'(xz[2]), 5);
        check("s2_z_x63", int'(xz[63]), 63);
        check("s2_z_x62", int'(xz[62]), 62);
        check("s2_z_x56", int'(xz[56]), 35);
        check("s2_r_x8", int'(xr[8]), 8);

        // 3: short block then a full ramp
        send_words(100, 1, 11, 1'b1);
        check("s3_err", int'(err_r), 1);
        check("s3_hold_x10", int'(xr[10]), 10);
        check("s3_hold_blk", int'(blk_r), 0);
        send_words(200, 1, 64, 1'b1);
        check("s3_r_x63", int'(xr[63]), 263);
        check("s3_z_x8", int'(xz[8]), 202);

        // 4: in_valid low every third cycle
        w = 0; c = 0;
        while (w < 64) begin
            if (c % 3 == 2) begin
                drive(1'b0, 16'sd0, 1'b0);
            end else begin
                drive(1'b1, 16'(-w), w == 63);
                w++;
            end
            c++;
        end
        check("s4_blk", int'(blk_r), 1);
        check("s4_x40", int'(xr[40]), -40);

        // 5: reset after word 30, then a full block
        send_words(500, 1, 31, 1'b0);
        rst = 1'b1;
        drive(1'b0, 16'sd0, 1'b0);
        rst = 1'b0;
        blk_t.delete(); ov_t.delete();
        nz = 0;
        for (int i = 0; i < 64; i++) if (xr[i] != 0 || xz[i] != 0) nz++;
        check("s5_x_zero", nz, 0);
        idle(1);
        send_words(700, 1, 63, 1'b0);
        check("s5_no_blk", blk_t.size(), 0);
        check("s5_no_ov", ov_t.size(), 0);
        drive(1'b1, 16'sd763, 1'b1);
        check("s5_blk", int'(blk_r), 1);
        check("s5_x63", int'(xr[63]), 763);

        // 6: back-to-back, second block missing in_last
        idle(40);
        blk_t.delete(); ov_t.delete(); n_err = 0;
        send_words(0, 1, 64, 1'b1);
        send_words(0, -1, 64, 1'b0);
        idle(40);
        check("s6_blk_count", blk_t.size(), 2);
        check("s6_ov_count", ov_t.size(), 2);
        check("s6_err_count", n_err, 1);
        if (blk_t.size() == 2 && ov_t.size() == 2) begin
            check("s6_blk_gap", blk_t[1] - blk_t[0], 64);
            check("s6_ov0_lat", ov_t[0] - blk_t[0], LAT);
            check("s6_ov1_lat", ov_t[1] - blk_t[1], LAT);
        end
        check("s6_x7", int'(xr[7]), -7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/idct_block_loader.md
# idct_block_loader

Input stage placed directly upstream of the `IDCT` pipeline. It accepts one 16-bit DCT coefficient per cycle over a valid/ready stream and optionally de-zigzags it into raster order. Each completed 64-coefficient block is presented as a registered parallel vector on `x0..x63`, which ties 1:1 to the `IDCT` `x*` inputs. It also generates a block-valid tag and delays it by the `IDCT` pipeline latency, so downstream logic knows which `out*` cycle carries a real block.

## Interface
- `WIDTH`, 16: coefficient width in bits, signed.
- `ZIGZAG`, 1: 1 = stream is in JPEG zigzag order; 0 = stream is in raster order.
- `IDCT_LATENCY`, 29: delay in cycles from `blk_valid` to `idct_out_valid`.

- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  signed coefficient.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  marks the final coefficient of a block; qualified by `in_valid`.
- `in_ready`  out  1  block accepts `in_data`.
- `x0`..`x63`  out  WIDTH each  registered signed block vector in raster order; connects to `IDCT` `x0..x63`.
- `blk_valid`  out  1  one-cycle pulse: `x*` now holds a newly completed block.
- `idct_out_valid`  out  1  `blk_valid` delayed by `IDCT_LATENCY`; qualifies `IDCT` `out*`.
- `err_len`  out  1  one-cycle pulse: a block-length violation was detected.

## Operation
- **Accept rule.** A word is accepted on a rising edge where `in_valid && in_ready`.
- **in_ready.** Registered signal. It is 0 during reset and 1 from the first edge after `rst` drops. The block never back-pressures otherwise.
- **Fill counter.** A 6-bit counter `cnt` (0..63) selects the destination index: `dst = ZIGZAG ? ZZ[cnt] : cnt`. The accepted word is written to `shadow[dst]`.
- **ZZ table.** ZZ = 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- **Block completion.** When a word is accepted with `cnt == 63`, at that same edge:
  - `x*` is loaded from `shadow`, with the incoming word merged at `dst`.
  - `blk_valid` goes to 1 for exactly one cycle.
  - `cnt` returns to 0.
  - If `in_last` was 0 on that word, `err_len` also pulses, but the block is still delivered.
- **Short block.** A word accepted with `in_last == 1` and `cnt < 63`:
  - The partial block is discarded and `cnt` returns to 0.
  - `x*` is unchanged and `blk_valid` stays 0.
  - `err_len` pulses for one cycle.
- **Double buffering.** `x*` holds the last completed block until the next completion. Filling of `shadow` for the next block may start the cycle after completion, so back-to-back blocks have no gap.
- **Valid tag.** `idct_out_valid` comes from an `IDCT_LATENCY`-deep shift register fed by `blk_valid`. It does not depend on the stream.
- **Reset.** Reset at any time, including mid-block, discards the partial block. Reset values:
  - `cnt` = 0, shadow contents don't-care.
  - `x0..x63` = 0.
  - `blk_valid`, `idct_out_valid`, `err_len`, `in_ready` = 0.
  - Valid-tag shift register cleared.

## Timing
- Let T be the edge that accepts coefficient 63.
- `x*` holds the new block, and `blk_valid` = 1, during the cycle that starts at T.
- `IDCT` samples `x*` at T+1.
- `idct_out_valid` = 1 during the cycle that starts at edge T + `IDCT_LATENCY`. With the default of 29, it coincides with `IDCT` presenting that block's result.
- `err_len` is registered and asserted during the cycle after the offending accept.
- **Minimum block period:** 64 cycles. `blk_valid` pulses are at least 64 cycles apart.
- **in_valid gaps:** stretch the fill; no state is lost.
- **Shift register:** each pulse is tracked independently, so overlapping blocks in flight produce separate `idct_out_valid` pulses.

## Test plan
1. **Raster ramp.** `ZIGZAG=0`, stream 0,-1,…,-63 with `in_last` on word 63.
   - Required: `x[i] = -i`, exactly one `blk_valid` pulse, `idct_out_valid` 29 cycles later.
   - Connected `IDCT` `out0` = 0xFF53 and `out8` = 0x00B0.
2. **Zigzag mapping.** `ZIGZAG=1`, stream value k at position k.
   - Required: `x0=0`, `x8=2`, `x16=3`, `x2=5`, `x63=63`, `x62=62`, `x56=35`.
3. **Short block.** `in_last` on word 10, then one full 64-word ramp.
   - Required: `err_len` pulses once and `x*` is unchanged after the first burst.
   - After the second burst, `x*` equals the ramp.
4. **Stalls.** A full block with `in_valid` low on every 3rd cycle.
   - Required: same `x*` as scenario 1, with `blk_valid` one cycle after the 64th accept.
5. **Reset mid-block.** Assert `rst` for 1 cycle after word 30, then send a full block.
   - Required: all `x*` = 0 until that block completes.
   - Required: no `blk_valid` or `idct_out_valid` from the aborted data.
6. **Back-to-back blocks.** Two blocks with no gap; the second has `in_last` = 0 on word 63.
   - Required: two `blk_valid` pulses exactly 64 cycles apart.
   - Required: one `err_len` pulse, and the second block is still delivered.
   - Required: two `idct_out_valid` pulses, each 29 cycles after its `blk_valid`.
